// File: rtl/inst_queue_pw.sv
// Decoded-instruction queue: compacts sparse fetch groups into a circular buffer
// and presents up to DISP_W packets per cycle from the head for dispatch.
module inst_queue_pw #(
    parameter int DEPTH        = 32,
    parameter int FETCH_W      = 8,
    parameter int DISP_W       = 4,
    parameter int PKT_W        = 128,
    parameter int BR_BIT       = 127,
    parameter int PARTIAL_DISP = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         decodeReady_i,
    input  logic [FETCH_W-1:0]           decodedVector_i,
    input  logic [FETCH_W*PKT_W-1:0]     decodedPacket_i,
    output logic                         stallFetch_o,
    output logic                         instBufferReady_o,
    output logic [DISP_W-1:0]            dispValid_o,
    output logic [DISP_W*PKT_W-1:0]      decodedPacket_o,
    output logic [$clog2(DISP_W+1)-1:0]  branchCount_o,
    output logic [$clog2(DEPTH):0]       instCount_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(DISP_W+1);

    // Handshake: decodeReady_i is the fetch-side valid and ~stallFetch_o the ready;
    // a group transfers only in a cycle where both hold, and a refused group is dropped
    // here (fetch must re-present it). stallFetch_o depends only on registered count.
    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    head_ptr, tail_ptr;
    logic [CW-1:0]    count;

    logic             wr_ok, wr_en;
    logic [CW-1:0]    nw, nr, avail;
    logic [AW-1:0]    wr_off [FETCH_W];
    logic [AW-1:0]    off_acc;
    logic [BCW-1:0]   br_acc;

    assign stallFetch_o      = (CW'(DEPTH) - count) < CW'(FETCH_W);
    assign wr_ok             = decodeReady_i & ~stallFetch_o;
    assign wr_en             = wr_ok & ~flush_i & ~reset;
    assign instBufferReady_o = (avail != '0);
    assign instCount_o       = count;
    assign nr                = stall_i ? '0 : avail;

    // Each valid lane lands at tail + (number of valid lanes below it).
    always_comb begin
        off_acc = '0;
        nw      = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            wr_off[k] = off_acc;
            off_acc   = off_acc + AW'(decodedVector_i[k]);
            nw        = nw + CW'(decodedVector_i[k]);
        end
        if (!wr_ok) nw = '0;
    end

    always_comb begin
        avail = '0;
        if (PARTIAL_DISP != 0)
            avail = (count < CW'(DISP_W)) ? count : CW'(DISP_W);
        else if (count >= CW'(DISP_W))
            avail = CW'(DISP_W);
    end

    always_comb begin
        dispValid_o     = '0;
        decodedPacket_o = '0;
        br_acc          = '0;
        for (int j = 0; j < DISP_W; j++) begin
            dispValid_o[j]                     = CW'(j) < avail;
            decodedPacket_o[j*PKT_W +: PKT_W]  = mem[head_ptr + AW'(j)];
            br_acc = br_acc + BCW'(dispValid_o[j] & decodedPacket_o[j*PKT_W + BR_BIT]);
        end
        branchCount_o = br_acc;
    end

    // Storage is never cleared; only pointers and count are reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en && decodedVector_i[k])
                mem[tail_ptr + wr_off[k]] <= decodedPacket_i[k*PKT_W +: PKT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + nr[AW-1:0];
            tail_ptr <= tail_ptr + nw[AW-1:0];
            count    <= count + nw - nr;
        end
    end
endmodule
